// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential unsigned divider.
// Optional feature macro used by the top level: DIVIDER_OVERFLOW_CHECK_EN.
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   prem_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+2:0] trial;

  assign shifted = {prem_i, bit_i};
  assign trial   = {1'b0, shifted} - {3'b000, divisor_i};
  // A clear sign bit means the shifted remainder covered the divisor.
  assign qbit_o  = ~trial[WIDTH+2];
  assign prem_o  = qbit_o ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);

endmodule

// File: rtl/sequential_unsigned_divider.sv
// Multi-cycle 2*WIDTH / WIDTH restoring divider, one quotient bit per cycle.
// Define DIVIDER_OVERFLOW_CHECK_EN to flag overflow / divide-by-zero early.
module sequential_unsigned_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_err,
  output state_t             dbg_state
);

  // Handshake: start is only looked at in IDLE, where it captures both
  // operands on that edge; done pulses for one cycle when quotient,
  // remainder and div_err become valid, and they hold until the next done.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   step_prem;
  logic             step_qbit;
  logic             ovf;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .prem_i    (prem_q),
    .bit_i     (shreg_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

`ifdef DIVIDER_OVERFLOW_CHECK_EN
  assign ovf = (dividend[2*WIDTH-1:WIDTH] >= divisor);
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shreg_d = shreg_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dsr_d   = divisor;
          prem_d  = {1'b0, dividend[2*WIDTH-1:WIDTH]};
          shreg_d = dividend[WIDTH-1:0];
          cnt_d   = '0;
          if (ovf) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend[WIDTH-1:0];
            err_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Low dividend bits shift out at the top while quotient bits fill the bottom.
        prem_d  = step_prem;
        shreg_d = {shreg_q[WIDTH-2:0], step_qbit};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = {shreg_q[WIDTH-2:0], step_qbit};
          rem_d   = step_prem[WIDTH-1:0];
          err_d   = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shreg_q <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shreg_q <= shreg_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sequential_unsigned_divider.sv
// Directed and random checks of sequential_unsigned_divider at WIDTH=16.
// Overflow vectors are exercised when DIVIDER_OVERFLOW_CHECK_EN is defined.
module tb_sequential_unsigned_divider;
  import divider_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_err;
  state_t         dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [2*W-1:0] exp_q[$];

  sequential_unsigned_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge of cycle 1.
  task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dsr);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = W'($urandom_range(0, 65535));
  endtask

  // Samples from cycle k0 onward; on done also checks that it drops next cycle.
  task automatic wait_done(input int k0, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int k = k0; k <= 40; k++) begin
      busy_n += int'(busy);
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat != 0) begin
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic do_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dsr,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                       input int elat, input int ebusy);
    int lat, bn;
    start_op(dvd, dsr);
    exp_done++;
    wait_done(1, lat, bn);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_cycles"}, 32'(bn), 32'(ebusy));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_div_err"}, 32'(div_err), 32'(ee));
  endtask

  initial begin
    int lat, bn, d0;
    logic [2*W-1:0] dvd, e;
    logic [W-1:0] dsr, hi, lo;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_err", 32'(div_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    do_op("d100000_300", 32'd100000, 16'd300, 16'd333, 16'd100, 1'b0, 17, 16);
    do_op("dFFFE0001_FFFF", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 17, 16);
    do_op("d0_5", 32'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17, 16);
    do_op("dFFFF_1", 32'h0000FFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 17, 16);
    do_op("d12345678_1235", 32'h12345678, 16'h1235, 16'hFFF6, 16'd3210, 1'b0, 17, 16);
    do_op("d7FFFFFFF_8000", 32'h7FFFFFFF, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b0, 17, 16);
    do_op("d1000_7", 32'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 17, 16);

`ifdef DIVIDER_OVERFLOW_CHECK_EN
    do_op("ovf_div0", 32'h12345678, 16'd0, 16'hFFFF, 16'h5678, 1'b1, 1, 0);
    do_op("ovf_hi_eq", 32'h00010000, 16'd1, 16'hFFFF, 16'h0000, 1'b1, 1, 0);
`endif

    // start re-pulsed mid-operation must be ignored
    start_op(32'd100000, 16'd300);
    exp_done++;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 16'd1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(6, lat, bn);
    check("repulse_latency", 32'(lat), 32'd17);
    check("repulse_busy_cycles", 32'(bn), 32'd11);
    check("repulse_quotient", 32'(quotient), 32'd333);
    check("repulse_remainder", 32'(remainder), 32'd100);

    // results hold while the next operation is in flight
    start_op(32'd1000, 16'd7);
    exp_done++;
    repeat (2) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd333);
    check("hold_remainder", 32'(remainder), 32'd100);
    wait_done(3, lat, bn);
    check("after_hold_latency", 32'(lat), 32'd17);
    check("after_hold_quotient", 32'(quotient), 32'd142);
    check("after_hold_remainder", 32'(remainder), 32'd6);

    // reset at cycle 8 aborts with no done
    start_op(32'h12345678, 16'h1235);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_div_err", 32'(div_err), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_op("post_abort", 32'h12345678, 16'h1235, 16'hFFF6, 16'd3210, 1'b0, 17, 16);

    // random non-overflow operands, back to back
    for (int i = 0; i < 1000; i++) begin
      dsr = W'($urandom_range(1, 65535));
      hi  = W'($urandom_range(0, 32'(dsr) - 1));
      lo  = W'($urandom_range(0, 65535));
      dvd = {hi, lo};
      exp_q.push_back({W'(dvd / 32'(dsr)), W'(dvd % 32'(dsr))});
      start_op(dvd, dsr);
      exp_done++;
      wait_done(1, lat, bn);
      check("rand_latency", 32'(lat), 32'd17);
      e = exp_q.pop_front();
      check("rand_quotient", 32'(quotient), 32'(e[2*W-1:W]));
      check("rand_remainder", 32'(remainder), 32'(e[W-1:0]));
    end

    check("done_count", 32'(done_cnt), 32'(exp_done));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequential_unsigned_divider.md
SEQUENTIAL_UNSIGNED_DIVIDER -- requirements
Module: sequential_unsigned_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; dividend is 2*WIDTH bits, divisor/quotient/remainder WIDTH bits.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  2*WIDTH  numerator, captured on accepted start.
REQ-007 divisor  input  WIDTH  denominator, captured on accepted start.
REQ-008 busy  output  1  high in CALC.
REQ-009 done  output  1  single-cycle pulse, results valid.
REQ-010 quotient  output  WIDTH  registered quotient.
REQ-011 remainder  output  WIDTH  registered remainder.
REQ-012 div_err  output  1  overflow/divide-by-zero flag, valid with done.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL perform restoring division, one quotient bit per CALC cycle, MSB first, using a WIDTH+1-bit partial remainder; no multi-bit combinational divide.
REQ-015 SHALL assert done exactly WIDTH+1 cycles after the edge accepting start (edge of acceptance = cycle 0).
REQ-016 busy SHALL be 1 from cycle 1 through cycle WIDTH, 0 otherwise.
REQ-017 quotient, remainder, div_err SHALL update only when entering DONE and hold until the next DONE or reset.
REQ-018 start in CALC or DONE SHALL be ignored; operands SHALL not be re-sampled.
REQ-019 Input changes after acceptance SHALL not affect the result.
REQ-020 For non-error cases SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor.
REQ-021 Overflow condition: dividend[2*WIDTH-1:WIDTH] >= divisor (includes divisor == 0).

Reset
REQ-022 rst_n low at a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_err=0, iteration counter=0.
REQ-023 Reset during CALC SHALL abort the operation with no done pulse; reset has priority over start.

Configuration
REQ-024 Macro DIVIDER_OVERFLOW_CHECK_EN SHALL gate overflow detection.
REQ-025 With DIVIDER_OVERFLOW_CHECK_EN defined: overflow detected at acceptance; FSM goes IDLE->DONE directly (done at cycle 1, busy never high), quotient = all ones, remainder = dividend[WIDTH-1:0], div_err=1.
REQ-026 Without it: div_err tied 0, all operations take the full WIDTH+1 latency, results for overflow inputs unspecified (not checked).

Structure
REQ-027 Package divider_pkg SHALL hold the state enumeration (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-028 Sub-module divider_step SHALL implement one combinational restoring step (shift in dividend bit, trial subtract, select, output quotient bit); instantiated once.
REQ-029 Iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=16)
REQ-030 dividend=100000, divisor=300, start 1 cycle -> done at cycle 17, quotient=333, remainder=100, div_err=0.
REQ-031 dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0, done at cycle 17.
REQ-032 With macro: divisor=0 and dividend=0x00010000/divisor=1 -> done at cycle 1, quotient=0xFFFF, remainder=low half, div_err=1.
REQ-033 start re-pulsed with new operands at cycle 5 -> ignored, original result delivered at cycle 17.
REQ-034 rst_n low at cycle 8 of an operation -> no done, all outputs 0; next start completes normally.
REQ-035 1000 random non-overflow pairs back-to-back -> REQ-020 holds for each, one done per start.
